// File: rtl/mult_div_if.sv
// Issue/result bundle between the execute stage and the iterative multiply/divide unit.
interface mult_div_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             abort;
  logic             busy;
  logic             done;
  logic             HI_write_enable;
  logic             LO_write_enable;
  logic [WIDTH-1:0] HI_result;
  logic [WIDTH-1:0] LO_result;

  modport master (
    output start, op, operand_a, operand_b, abort,
    input  busy, done, HI_write_enable, LO_write_enable, HI_result, LO_result
  );

  modport slave (
    input  start, op, operand_a, operand_b, abort,
    output busy, done, HI_write_enable, LO_write_enable, HI_result, LO_result
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit producing HI/LO write data.
// FAST_MULT_EN: single-cycle multiplier for MULT/MULTU; divides stay iterative.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  mult_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q;
  logic [1:0]       op_q;
  logic             a_neg_q, b_neg_q;
  logic [WIDTH-1:0] addend_q;   // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] hi_res_q, lo_res_q;

  logic             launch, sgn_in, a_neg_in, b_neg_in, fast_mul;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] step_hi, step_lo, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] neg_prod;
  logic             is_div, sign_diff, div_zero;

  assign launch   = (state_q == IDLE || state_q == DONE) && bus.start && !bus.abort;
  assign sgn_in   = ~bus.op[0];
  assign a_neg_in = sgn_in & bus.operand_a[WIDTH-1];
  assign b_neg_in = sgn_in & bus.operand_b[WIDTH-1];
  assign a_mag_in = a_neg_in ? -bus.operand_a : bus.operand_a;
  assign b_mag_in = b_neg_in ? -bus.operand_b : bus.operand_b;

`ifdef FAST_MULT_EN
  logic [2*WIDTH-1:0] a_ext, b_ext, fast_prod;
  assign a_ext     = {{WIDTH{a_neg_in}}, bus.operand_a};
  assign b_ext     = {{WIDTH{b_neg_in}}, bus.operand_b};
  assign fast_prod = a_ext * b_ext;
  assign fast_mul  = ~bus.op[1];
`else
  assign fast_mul  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (launch) state_d = fast_mul ? DONE : CALC;
        else        state_d = IDLE;
      end
      CALC: begin
        if (bus.abort)                 state_d = IDLE;
        else if (count_q == CW'(1))    state_d = FIX;
      end
      FIX:     state_d = bus.abort ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // One radix-2 step: shift-add multiply or restoring divide on {hi_q, lo_q}.
  always_comb begin
    is_div    = op_q[1];
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, addend_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, addend_q};
    step_hi   = mul_sum[WIDTH:1];
    step_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign correction; a zero divisor leaves the all-ones quotient untouched.
  always_comb begin
    sign_diff = a_neg_q ^ b_neg_q;
    div_zero  = (addend_q == '0);
    neg_prod  = -{hi_q, lo_q};
    fix_hi    = hi_q;
    fix_lo    = lo_q;
    if (is_div) begin
      if (sign_diff && !div_zero) fix_lo = -lo_q;
      if (a_neg_q)                fix_hi = -hi_q;
    end else if (sign_diff) begin
      fix_hi = neg_prod[2*WIDTH-1:WIDTH];
      fix_lo = neg_prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      addend_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_res_q <= '0;
      lo_res_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, DONE: begin
          if (launch) begin
            op_q     <= bus.op;
            a_neg_q  <= a_neg_in;
            b_neg_q  <= b_neg_in;
            count_q  <= CW'(WIDTH);
            hi_q     <= '0;
            addend_q <= bus.op[1] ? b_mag_in : a_mag_in;
            lo_q     <= bus.op[1] ? a_mag_in : b_mag_in;
`ifdef FAST_MULT_EN
            if (fast_mul) begin
              hi_res_q <= fast_prod[2*WIDTH-1:WIDTH];
              lo_res_q <= fast_prod[WIDTH-1:0];
            end
`endif
          end
        end
        CALC: begin
          if (!bus.abort) begin
            count_q <= count_q - 1'b1;
            hi_q    <= step_hi;
            lo_q    <= step_lo;
          end
        end
        FIX: begin
          if (!bus.abort) begin
            hi_res_q <= fix_hi;
            lo_res_q <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy            = (state_q == CALC) || (state_q == FIX);
  assign bus.done            = (state_q == DONE);
  assign bus.HI_write_enable = (state_q == DONE);
  assign bus.LO_write_enable = (state_q == DONE);
  assign bus.HI_result       = hi_res_q;
  assign bus.LO_result       = lo_res_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (default or FAST_MULT_EN build).
module tb_mult_div_unit;
  localparam int W = 32;
`ifdef FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 2;
`endif
  localparam int DIV_LAT = W + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   done_pulses = 0;
  int   lat;

  mult_div_if #(.WIDTH(W)) mdi ();
  mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(mdi));

  always #5 clk = ~clk;
  always @(posedge clk) if (mdi.done === 1'b1) done_pulses++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge (edge k).
  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    mdi.start = 1'b1; mdi.op = op; mdi.operand_a = a; mdi.operand_b = b;
    @(negedge clk);
    mdi.start = 1'b0;
    lat = 1;
  endtask

  // Advances until done; lat ends as the cycle index after edge k (k+lat).
  task automatic wait_done(input bit inj, input int inj_at,
                           input logic [W-1:0] ia, input logic [W-1:0] ib);
    while (mdi.done !== 1'b1 && lat < 100) begin
      if (inj && lat == inj_at) begin
        mdi.start = 1'b1; mdi.op = 2'b01; mdi.operand_a = ia; mdi.operand_b = ib;
      end else if (inj && lat == inj_at + 1) begin
        mdi.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    mdi.start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int exp_lat,
                              input logic [W-1:0] hi, input logic [W-1:0] lo);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_hi"}, 64'(mdi.HI_result), 64'(hi));
    check({tag, "_lo"}, 64'(mdi.LO_result), 64'(lo));
    check({tag, "_we"}, {62'd0, mdi.HI_write_enable, mdi.LO_write_enable}, 64'd3);
  endtask

  initial begin
    mdi.start = 1'b0; mdi.abort = 1'b0; mdi.op = 2'b00;
    mdi.operand_a = '0; mdi.operand_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(mdi.busy), 64'd0);
    check("rst_done", 64'(mdi.done), 64'd0);
    check("rst_we", {62'd0, mdi.HI_write_enable, mdi.LO_write_enable}, 64'd0);
    check("rst_hi", 64'(mdi.HI_result), 64'd0);
    check("rst_lo", 64'(mdi.LO_result), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    if (MUL_LAT > 1) check("multu_busy", 64'(mdi.busy), 64'd1);
    wait_done(1'b0, 0, '0, '0);
    check_result("multu_max", MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001);
    @(negedge clk);
    check("done_pulse_end", 64'(mdi.done), 64'd0);
    check("hold_hi", 64'(mdi.HI_result), 64'h0000_0000_FFFF_FFFE);

    start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(1'b0, 0, '0, '0);
    check_result("mult_neg", MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    @(negedge clk);

    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(1'b0, 0, '0, '0);
    check_result("div_neg", DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    @(negedge clk);

    start_op(2'b11, 32'd100, 32'd0);
    wait_done(1'b0, 0, '0, '0);
    check_result("divu_zero", DIV_LAT, 32'd100, 32'hFFFF_FFFF);
    @(negedge clk);

    start_op(2'b10, 32'hFFFF_FFF9, 32'd0);
    wait_done(1'b0, 0, '0, '0);
    check_result("div_zero", DIV_LAT, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    @(negedge clk);

    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1'b0, 0, '0, '0);
    check_result("div_ovf", DIV_LAT, 32'h0000_0000, 32'h8000_0000);
    @(negedge clk);

    // Abort in cycle k+10: busy must drop in k+11 with no done.
    done_pulses = 0;
    start_op(2'b11, 32'd10, 32'd3);
    repeat (9) @(negedge clk);
    check("abort_busy_before", 64'(mdi.busy), 64'd1);
    mdi.abort = 1'b1;
    @(negedge clk);
    mdi.abort = 1'b0;
    check("abort_busy_after", 64'(mdi.busy), 64'd0);
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(done_pulses), 64'd0);
    check("abort_hi_kept", 64'(mdi.HI_result), 64'd0);
    check("abort_lo_kept", 64'(mdi.LO_result), 64'h0000_0000_8000_0000);

    // Start while busy must be ignored.
    start_op(2'b11, 32'd100, 32'd7);
    wait_done(1'b1, 5, 32'd50, 32'd5);
    check_result("busy_ignore", DIV_LAT, 32'd2, 32'd14);
    @(negedge clk);
    check("busy_ignore_idle", {62'd0, mdi.busy, mdi.done}, 64'd0);

    // Back-to-back: second start issued during the first done cycle.
    done_pulses = 0;
    start_op(2'b01, 32'h1234_5678, 32'h0000_0010);
    wait_done(1'b0, 0, '0, '0);
    check_result("b2b_first", MUL_LAT, 32'h0000_0001, 32'h2345_6780);
    start_op(2'b11, 32'd1000, 32'd10);
    wait_done(1'b0, 0, '0, '0);
    check_result("b2b_second", DIV_LAT, 32'd0, 32'd100);
    repeat (3) @(negedge clk);
    check("b2b_pulses", 64'(done_pulses), 64'd2);

    // Reset mid-operation.
    start_op(2'b11, 32'd10, 32'd3);
    repeat (4) @(negedge clk);
    check("rstmid_busy_before", 64'(mdi.busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_busy", 64'(mdi.busy), 64'd0);
    check("rstmid_done", 64'(mdi.done), 64'd0);
    check("rstmid_hi", 64'(mdi.HI_result), 64'd0);
    check("rstmid_lo", 64'(mdi.LO_result), 64'd0);
    start_op(2'b11, 32'd10, 32'd3);
    wait_done(1'b0, 0, '0, '0);
    check_result("rstmid_fresh", DIV_LAT, 32'd1, 32'd3);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
